// File: rtl/m_rect_fill.sv
// ---------------------------------------------------------------------------
// m_rect_fill
//
// Rectangle-fill drawing engine. Rectangle commands (two corners plus an
// RGB565 colour) arrive on a valid/ready handshake and are queued in a small
// FIFO. Each queued command is then rasterised row-major into one video
// memory write per cycle. The write port plugs straight into the vmem write
// side, and the display stage reads vmem on its own.
//
// Parameters
//   FIFO_DEPTH  command FIFO entries (power of 2, >= 2)
//   MAX_COORD   largest legal x/y; larger coordinates clip to this value
//
// Ports
//   w_clk        in   1   single clock for the whole block
//   w_rst_n      in   1   asynchronous active-low reset
//   i_cmd_valid  in   1   command present on i_x0..i_color
//   o_cmd_ready  out  1   FIFO can accept a command (registered !full)
//   i_x0, i_y0   in   8   first corner (inclusive)
//   i_x1, i_y1   in   8   second corner (inclusive), corners in any order
//   i_color      in   16  RGB565 fill colour
//   o_we         out  1   vmem write strobe
//   o_wadr       out  16  vmem address {y, x}
//   o_wdata      out  16  pixel colour
//   o_busy       out  1   FIFO non-empty or engine filling (registered)
//   o_done       out  1   one-cycle pulse with the last write of a rectangle
// ---------------------------------------------------------------------------
module m_rect_fill #(
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_COORD  = 239
) (
   input  logic        w_clk,
   input  logic        w_rst_n,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic [7:0]  i_x0,
   input  logic [7:0]  i_y0,
   input  logic [7:0]  i_x1,
   input  logic [7:0]  i_y1,
   input  logic [15:0] i_color,
   output logic        o_we,
   output logic [15:0] o_wadr,
   output logic [15:0] o_wdata,
   output logic        o_busy,
   output logic        o_done
);

   localparam int PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CntW = PtrW + 1;
   localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

   // Coordinates are 8 bits wide, so a clip limit above 255 can never bind.
   localparam int ClipLimit = (MAX_COORD > 255) ? 255 : MAX_COORD;
   localparam logic [7:0] MaxCoordC = 8'(ClipLimit);

   typedef struct packed {
      logic [7:0]  x0;
      logic [7:0]  y0;
      logic [7:0]  x1;
      logic [7:0]  y1;
      logic [15:0] color;
   } rectCmd_t;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StFill = 1'b1
   } fillState_t;

   // Command FIFO
   rectCmd_t         fifoMem_q [FIFO_DEPTH];
   logic [PtrW-1:0]  wrPtr_q;
   logic [PtrW-1:0]  rdPtr_q;
   logic [CntW-1:0]  count_q;
   logic [CntW-1:0]  count_d;
   logic             fifoEmpty;
   logic             fifoPush;
   logic             fifoPop;
   rectCmd_t         inCmd;
   rectCmd_t         headCmd;

   // Normalised view of the FIFO head
   logic [7:0]       normXLo;
   logic [7:0]       normXHi;
   logic [7:0]       normYLo;
   logic [7:0]       normYHi;

   // Fill engine
   fillState_t       state_q;
   logic [7:0]       cx_q;
   logic [7:0]       cy_q;
   logic [7:0]       xLo_q;
   logic [7:0]       xHi_q;
   logic [7:0]       yHi_q;
   logic [15:0]      color_q;

   function automatic logic [7:0] clipCoord(input logic [7:0] v);
      clipCoord = (v > MaxCoordC) ? MaxCoordC : v;
   endfunction

   // Ready is a registered copy of !full, so a pop in the same cycle as a
   // full FIFO does not open the door until the following cycle.
   assign fifoEmpty = (count_q == '0);
   assign fifoPush  = i_cmd_valid && o_cmd_ready;
   assign fifoPop   = (state_q == StIdle) && !fifoEmpty;
   assign inCmd     = {i_x0, i_y0, i_x1, i_y1, i_color};
   assign headCmd   = fifoMem_q[rdPtr_q];

   // Sort each axis first, then clip; clipping after sorting keeps lo <= hi,
   // so every rectangle covers at least one pixel.
   assign normXLo = clipCoord((headCmd.x0 < headCmd.x1) ? headCmd.x0 : headCmd.x1);
   assign normXHi = clipCoord((headCmd.x0 < headCmd.x1) ? headCmd.x1 : headCmd.x0);
   assign normYLo = clipCoord((headCmd.y0 < headCmd.y1) ? headCmd.y0 : headCmd.y1);
   assign normYHi = clipCoord((headCmd.y0 < headCmd.y1) ? headCmd.y1 : headCmd.y0);

   // Occupancy bookkeeping: a simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_d = count_q;
      case ({fifoPush, fifoPop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // Command storage. Contents need no reset: the pointers and count decide
   // which entries are live.
   always_ff @(posedge w_clk) begin
      if (fifoPush) begin
         fifoMem_q[wrPtr_q] <= inCmd;
      end
   end

   // FIFO pointers, occupancy and the registered ready flag. Pointers wrap
   // naturally because the depth is a power of two.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         o_cmd_ready <= 1'b1;
      end else begin
         if (fifoPush) begin
            wrPtr_q <= wrPtr_q + PtrW'(1);
         end
         if (fifoPop) begin
            rdPtr_q <= rdPtr_q + PtrW'(1);
         end
         count_q     <= count_d;
         o_cmd_ready <= (count_d != DepthC);
      end
   end

   // Fill engine. IDLE pops and latches the normalised command; FILL emits
   // one registered write per cycle, walking x first and then y, and returns
   // to IDLE on the last pixel. The IDLE visit between rectangles is the
   // single bubble cycle seen on o_we. o_busy is the registered version of
   // "FIFO non-empty or not IDLE", so it stays high through the o_done cycle
   // and drops one cycle later.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q <= StIdle;
         cx_q    <= '0;
         cy_q    <= '0;
         xLo_q   <= '0;
         xHi_q   <= '0;
         yHi_q   <= '0;
         color_q <= '0;
         o_we    <= 1'b0;
         o_wadr  <= '0;
         o_wdata <= '0;
         o_done  <= 1'b0;
         o_busy  <= 1'b0;
      end else begin
         o_busy <= !fifoEmpty || (state_q != StIdle);
         case (state_q)
            StIdle: begin
               o_we   <= 1'b0;
               o_done <= 1'b0;
               if (fifoPop) begin
                  xLo_q   <= normXLo;
                  xHi_q   <= normXHi;
                  yHi_q   <= normYHi;
                  color_q <= headCmd.color;
                  cx_q    <= normXLo;
                  cy_q    <= normYLo;
                  state_q <= StFill;
               end
            end
            StFill: begin
               o_we    <= 1'b1;
               o_wadr  <= {cy_q, cx_q};
               o_wdata <= color_q;
               o_done  <= 1'b0;
               if (cx_q == xHi_q) begin
                  if (cy_q == yHi_q) begin
                     o_done  <= 1'b1;
                     state_q <= StIdle;
                  end else begin
                     cx_q <= xLo_q;
                     cy_q <= cy_q + 8'd1;
                  end
               end else begin
                  cx_q <= cx_q + 8'd1;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_m_rect_fill.sv
// ---------------------------------------------------------------------------
// tb_m_rect_fill
//
// Self-checking bench for m_rect_fill. A queue-based behavioural model keeps
// the accepted commands and the pixel list of the rectangle being drawn and
// predicts every registered output each cycle; a compare process checks the
// DUT against it on every falling edge. Directed scenarios add literal
// expectations (addresses, counts, latencies) on a log of observed writes.
// ---------------------------------------------------------------------------
module tb_m_rect_fill;

   localparam int Depth    = 4;
   localparam int MaxCoord = 239;

   logic        w_clk = 1'b0;
   logic        w_rst_n;
   logic        i_cmd_valid;
   logic        o_cmd_ready;
   logic [7:0]  i_x0;
   logic [7:0]  i_y0;
   logic [7:0]  i_x1;
   logic [7:0]  i_y1;
   logic [15:0] i_color;
   logic        o_we;
   logic [15:0] o_wadr;
   logic [15:0] o_wdata;
   logic        o_busy;
   logic        o_done;

   m_rect_fill #(
      .FIFO_DEPTH(Depth),
      .MAX_COORD (MaxCoord)
   ) dut (
      .w_clk      (w_clk),
      .w_rst_n    (w_rst_n),
      .i_cmd_valid(i_cmd_valid),
      .o_cmd_ready(o_cmd_ready),
      .i_x0       (i_x0),
      .i_y0       (i_y0),
      .i_x1       (i_x1),
      .i_y1       (i_y1),
      .i_color    (i_color),
      .o_we       (o_we),
      .o_wadr     (o_wadr),
      .o_wdata    (o_wdata),
      .o_busy     (o_busy),
      .o_done     (o_done)
   );

   // 100 MHz-style clock, 10 time units per period
   always #5 w_clk = ~w_clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [7:0]  xLo;
      logic [7:0]  xHi;
      logic [7:0]  yLo;
      logic [7:0]  yHi;
      logic [15:0] color;
   } rect_t;

   typedef struct {
      logic [15:0] adr;
      logic [15:0] data;
   } pix_t;

   typedef struct {
      int          cyc;
      logic [15:0] adr;
      logic [15:0] data;
      logic        done;
   } wrLog_t;

   // Model state
   rect_t       cmdQ[$];
   pix_t        pixQ[$];
   bit          fillActive = 1'b0;
   int          pushCount  = 0;
   logic        eWe    = 1'b0;
   logic        eDone  = 1'b0;
   logic        eBusy  = 1'b0;
   logic        eReady = 1'b1;
   logic [15:0] eAdr   = 16'h0000;
   logic [15:0] eData  = 16'h0000;

   wrLog_t      wrLog[$];

   // Corner sorting and clipping straight from the command definition
   function automatic rect_t normalise(input logic [7:0] x0, input logic [7:0] y0,
                                       input logic [7:0] x1, input logic [7:0] y1,
                                       input logic [15:0] c);
      rect_t r;
      int xl, xh, yl, yh;
      xl = (x0 < x1) ? int'(x0) : int'(x1);
      xh = (x0 < x1) ? int'(x1) : int'(x0);
      yl = (y0 < y1) ? int'(y0) : int'(y1);
      yh = (y0 < y1) ? int'(y1) : int'(y0);
      if (xl > MaxCoord) xl = MaxCoord;
      if (xh > MaxCoord) xh = MaxCoord;
      if (yl > MaxCoord) yl = MaxCoord;
      if (yh > MaxCoord) yh = MaxCoord;
      r.xLo   = 8'(xl);
      r.xHi   = 8'(xh);
      r.yLo   = 8'(yl);
      r.yHi   = 8'(yh);
      r.color = c;
      return r;
   endfunction

   // Cycle counter used to time-stamp writes and pushes
   initial forever begin
      @(posedge w_clk);
      cyc = cyc + 1;
   end

   // Behavioural model: a rectangle becomes a row-major list of pixels when
   // it leaves the command queue; while a list is pending one pixel is
   // emitted per edge, otherwise the edge is an idle edge that may start the
   // next rectangle.
   initial forever begin
      @(posedge w_clk or negedge w_rst_n);
      if (!w_rst_n) begin
         cmdQ.delete();
         pixQ.delete();
         fillActive = 1'b0;
         eWe    = 1'b0;
         eDone  = 1'b0;
         eBusy  = 1'b0;
         eReady = 1'b1;
         eAdr   = 16'h0000;
         eData  = 16'h0000;
      end else begin
         rect_t r;
         pix_t  p;
         bit    acc;
         bit    busyNow;
         acc     = i_cmd_valid && eReady;
         busyNow = (cmdQ.size() != 0) || fillActive;
         if (fillActive) begin
            p     = pixQ.pop_front();
            eWe   = 1'b1;
            eAdr  = p.adr;
            eData = p.data;
            eDone = (pixQ.size() == 0);
            if (eDone) fillActive = 1'b0;
         end else begin
            eWe   = 1'b0;
            eDone = 1'b0;
            if (cmdQ.size() != 0) begin
               r = cmdQ.pop_front();
               for (int y = int'(r.yLo); y <= int'(r.yHi); y++) begin
                  for (int x = int'(r.xLo); x <= int'(r.xHi); x++) begin
                     pixQ.push_back('{adr: {8'(y), 8'(x)}, data: r.color});
                  end
               end
               fillActive = 1'b1;
            end
         end
         if (acc) begin
            cmdQ.push_back(normalise(i_x0, i_y0, i_x1, i_y1, i_color));
            pushCount = pushCount + 1;
         end
         eReady = (cmdQ.size() != Depth);
         eBusy  = busyNow;
      end
   end

   // Per-cycle compare against the model, plus a log of observed writes
   initial forever begin
      @(negedge w_clk);
      if (w_rst_n) begin
         total = total + 1;
         if ({o_we, o_done, o_busy, o_cmd_ready, o_wadr, o_wdata} !==
             {eWe, eDone, eBusy, eReady, eAdr, eData}) begin
            bad = bad + 1;
            $display("[TB] FAIL cycle %0d outputs: got we=%b done=%b busy=%b ready=%b adr=%h data=%h, expected we=%b done=%b busy=%b ready=%b adr=%h data=%h",
                     cyc, o_we, o_done, o_busy, o_cmd_ready, o_wadr, o_wdata,
                     eWe, eDone, eBusy, eReady, eAdr, eData);
         end
         if (o_we === 1'b1) begin
            wrLog.push_back('{cyc: cyc, adr: o_wadr, data: o_wdata, done: o_done});
         end
      end
   end

   // Literal comparison helper
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present a command and hold valid until the model records the push.
   // Valid stays asserted on return so callers can stream commands.
   task automatic applyStimulus(input logic [7:0] x0, input logic [7:0] y0,
                                input logic [7:0] x1, input logic [7:0] y1,
                                input logic [15:0] c, output int acceptCyc);
      int startCount;
      startCount  = pushCount;
      i_x0        = x0;
      i_y0        = y0;
      i_x1        = x1;
      i_y1        = y1;
      i_color     = c;
      i_cmd_valid = 1'b1;
      acceptCyc   = -1;
      for (int n = 0; n < 200; n++) begin
         @(posedge w_clk);
         #1;
         if (pushCount != startCount) begin
            acceptCyc = cyc;
            break;
         end
      end
      checkOutput("command accepted", 32'(acceptCyc >= 0), 32'd1);
   endtask

   // Wait (bounded) until both the model and the DUT are idle
   task automatic waitIdle(input int maxCyc);
      int n;
      n = 0;
      while ((cmdQ.size() != 0 || fillActive || eBusy || o_busy !== 1'b0) && n < maxCyc) begin
         @(posedge w_clk);
         #1;
         n = n + 1;
      end
      checkOutput("idle within bound", 32'(n < maxCyc), 32'd1);
   endtask

   initial begin
      int  t0;
      int  tDummy;
      int  acc[6];
      bit  noGap;
      logic [15:0] expData;
      logic [15:0] expAdr;

      w_rst_n     = 1'b0;
      i_cmd_valid = 1'b0;
      i_x0        = 8'd0;
      i_y0        = 8'd0;
      i_x1        = 8'd0;
      i_y1        = 8'd0;
      i_color     = 16'h0000;
      repeat (3) @(posedge w_clk);
      @(negedge w_clk);
      #2 w_rst_n = 1'b1;
      @(posedge w_clk);
      #1;

      // Reset values
      checkOutput("reset we",    32'(o_we),        32'd0);
      checkOutput("reset wadr",  32'(o_wadr),      32'd0);
      checkOutput("reset wdata", 32'(o_wdata),     32'd0);
      checkOutput("reset done",  32'(o_done),      32'd0);
      checkOutput("reset busy",  32'(o_busy),      32'd0);
      checkOutput("reset ready", 32'(o_cmd_ready), 32'd1);

      // Single pixel
      wrLog.delete();
      applyStimulus(8'd10, 8'd20, 8'd10, 8'd20, 16'hF800, t0);
      i_cmd_valid = 1'b0;
      waitIdle(100);
      checkOutput("single count", 32'(wrLog.size()), 32'd1);
      if (wrLog.size() > 0) begin
         checkOutput("single adr",     32'(wrLog[0].adr),    32'h140A);
         checkOutput("single data",    32'(wrLog[0].data),   32'hF800);
         checkOutput("single done",    32'(wrLog[0].done),   32'd1);
         checkOutput("single latency", 32'(wrLog[0].cyc - t0), 32'd2);
      end

      // Swapped and clipped corners
      wrLog.delete();
      applyStimulus(8'd250, 8'd3, 8'd237, 8'd1, 16'h07E0, t0);
      i_cmd_valid = 1'b0;
      waitIdle(100);
      checkOutput("clip count", 32'(wrLog.size()), 32'd9);
      if (wrLog.size() == 9) begin
         checkOutput("clip first adr",  32'(wrLog[0].adr),  32'h01ED);
         checkOutput("clip last adr",   32'(wrLog[8].adr),  32'h03EF);
         checkOutput("clip first done", 32'(wrLog[0].done), 32'd0);
         checkOutput("clip last done",  32'(wrLog[8].done), 32'd1);
         checkOutput("clip data",       32'(wrLog[4].data), 32'h07E0);
      end

      // FIFO backpressure: six 2x2 rectangles with valid held throughout
      wrLog.delete();
      for (int k = 0; k < 6; k++) begin
         applyStimulus(8'(20 * k), 8'd50, 8'(20 * k + 1), 8'd51, 16'hA000 + 16'(k), acc[k]);
         if (k == 3) checkOutput("ready after 4th push", 32'(o_cmd_ready), 32'd1);
         if (k == 4) checkOutput("ready after 5th push", 32'(o_cmd_ready), 32'd0);
      end
      i_cmd_valid = 1'b0;
      waitIdle(300);
      checkOutput("bp count", 32'(wrLog.size()), 32'd24);
      if (wrLog.size() == 24) begin
         for (int i = 0; i < 24; i++) begin
            expData = 16'hA000 + 16'(i / 4);
            expAdr  = {8'(50 + (i % 4) / 2), 8'(20 * (i / 4) + (i % 2))};
            checkOutput("bp data", 32'(wrLog[i].data), 32'(expData));
            checkOutput("bp adr",  32'(wrLog[i].adr),  32'(expAdr));
         end
         for (int r = 1; r < 6; r++) begin
            checkOutput("bp bubble", 32'(wrLog[4 * r].cyc - wrLog[4 * r - 1].cyc), 32'd2);
         end
      end

      // Full screen
      wrLog.delete();
      applyStimulus(8'd0, 8'd0, 8'd239, 8'd239, 16'h001F, t0);
      i_cmd_valid = 1'b0;
      waitIdle(60000);
      checkOutput("full count", 32'(wrLog.size()), 32'd57600);
      if (wrLog.size() == 57600) begin
         noGap = 1'b1;
         for (int i = 1; i < 57600; i++) begin
            if (wrLog[i].cyc != wrLog[i - 1].cyc + 1) noGap = 1'b0;
         end
         checkOutput("full gapless",   32'(noGap),            32'd1);
         checkOutput("full first adr", 32'(wrLog[0].adr),     32'h0000);
         checkOutput("full last adr",  32'(wrLog[57599].adr), 32'hEFEF);
         checkOutput("full last done", 32'(wrLog[57599].done), 32'd1);
      end
      checkOutput("full busy low", 32'(o_busy), 32'd0);

      // Reset during the 100th write of a 20x20 fill with two commands queued
      wrLog.delete();
      applyStimulus(8'd0, 8'd0, 8'd19, 8'd19, 16'h1234, t0);
      applyStimulus(8'd30, 8'd30, 8'd31, 8'd31, 16'h5678, tDummy);
      applyStimulus(8'd40, 8'd40, 8'd41, 8'd41, 16'h9ABC, tDummy);
      i_cmd_valid = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         @(negedge w_clk);
         #1;
         if (wrLog.size() >= 100) break;
      end
      checkOutput("reached 100th write", 32'(wrLog.size()), 32'd100);
      checkOutput("we before reset",     32'(o_we),         32'd1);
      w_rst_n = 1'b0;
      #1;
      checkOutput("we during reset",   32'(o_we),   32'd0);
      checkOutput("busy during reset", 32'(o_busy), 32'd0);
      repeat (2) @(posedge w_clk);
      @(negedge w_clk);
      #2 w_rst_n = 1'b1;
      repeat (40) @(posedge w_clk);
      #1;
      checkOutput("writes after reset", 32'(wrLog.size()), 32'd100);
      checkOutput("busy after reset",   32'(o_busy),       32'd0);
      checkOutput("ready after reset",  32'(o_cmd_ready),  32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #5000000;
      bad = bad + 1;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
